// File: rtl/traffic_conflict_monitor_if.sv
// Lamp-code sampling and fault-reporting signals between the lamp-drive tap and the monitor.
// The master side drives the sampled codes and acknowledge; the slave side (the monitor) reports the fault.
interface traffic_conflict_monitor_if;
  logic [1:0] highway;
  logic [1:0] cross_road;
  logic       fault_ack;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;

  modport master (
    output highway, cross_road, fault_ack,
    input  fault, fault_code, flash
  );

  modport slave (
    input  highway, cross_road, fault_ack,
    output fault, fault_code, flash
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor for traffic-light lamp codes: checks aspect rules every clock,
// latches the first violation and flashes until it is acknowledged with both roads red.
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MIN_ALLRED = 2,
  parameter int FLASH_DIV  = 8
) (
  input logic                       clk,
  input logic                       clear,
  traffic_conflict_monitor_if.slave bus
);
  localparam logic [1:0]  RED        = 2'b00;
  localparam logic [1:0]  YEL        = 2'b01;
  localparam logic [1:0]  GRN        = 2'b10;
  localparam logic [1:0]  INV        = 2'b11;
  localparam logic [7:0]  MIN_YEL_C  = 8'(MIN_YELLOW);
  localparam logic [7:0]  MIN_CLR_C  = 8'(MIN_ALLRED);
  localparam logic [15:0] FLASH_TC   = 16'(FLASH_DIV - 1);

  typedef enum logic [1:0] {ST_ARM = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_t;

  typedef enum logic [2:0] {
    C_NONE      = 3'd0,
    C_INVALID   = 3'd1,
    C_CONFLICT  = 3'd2,
    C_BAD_SEQ   = 3'd3,
    C_SHORT_YEL = 3'd4,
    C_SHORT_CLR = 3'd5
  } code_t;

  state_t      state_r;
  logic [1:0]  prev_hw_r;
  logic [1:0]  prev_cr_r;
  logic [7:0]  yel_hw_r;
  logic [7:0]  yel_cr_r;
  logic [7:0]  allred_r;
  logic [15:0] flash_cnt_r;
  logic        fault_r;
  logic [2:0]  code_r;
  logic        flash_r;

  code_t       viol_s;
  logic        both_red_s;
  logic        prev_both_red_s;
  logic        ack_ok_s;

  function automatic logic bad_step(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev == GRN) && (cur == RED)) ||
           ((prev == YEL) && (cur == GRN)) ||
           ((prev == RED) && (cur == YEL));
  endfunction

  function automatic logic short_yellow(input logic [1:0] prev, input logic [1:0] cur,
                                        input logic [7:0] cnt);
    return (prev == YEL) && (cur == RED) && (cnt < MIN_YEL_C);
  endfunction

  // A run counter restarts at 1 on the arm sample or after a miss, and saturates at 255.
  function automatic logic [7:0] run_next(input logic hit, input logic load, input logic [7:0] cnt);
    logic [7:0] nxt;
    if (!hit) begin
      nxt = 8'd0;
    end else if (load) begin
      nxt = 8'd1;
    end else if (cnt == 8'hFF) begin
      nxt = 8'hFF;
    end else begin
      nxt = cnt + 8'd1;
    end
    return nxt;
  endfunction

  // Classify the current sample; only invalid/conflict are checked before the monitor is armed.
  always_comb begin
    both_red_s      = (bus.highway == RED) && (bus.cross_road == RED);
    prev_both_red_s = (prev_hw_r == RED) && (prev_cr_r == RED);
    ack_ok_s        = bus.fault_ack && both_red_s;
    viol_s          = C_NONE;
    if ((bus.highway == INV) || (bus.cross_road == INV)) begin
      viol_s = C_INVALID;
    end else if ((bus.highway != RED) && (bus.cross_road != RED)) begin
      viol_s = C_CONFLICT;
    end else if (state_r != ST_RUN) begin
      viol_s = C_NONE;
    end else if (bad_step(prev_hw_r, bus.highway) || bad_step(prev_cr_r, bus.cross_road)) begin
      viol_s = C_BAD_SEQ;
    end else if (short_yellow(prev_hw_r, bus.highway, yel_hw_r) ||
                 short_yellow(prev_cr_r, bus.cross_road, yel_cr_r)) begin
      viol_s = C_SHORT_YEL;
    end else if ((((prev_hw_r == RED) && (bus.highway == GRN)) ||
                  ((prev_cr_r == RED) && (bus.cross_road == GRN))) &&
                 prev_both_red_s && (allred_r < MIN_CLR_C)) begin
      viol_s = C_SHORT_CLR;
    end else begin
      viol_s = C_NONE;
    end
  end

  // Monitor FSM with history registers, fault latch and flash divider.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r     <= ST_ARM;
      prev_hw_r   <= RED;
      prev_cr_r   <= RED;
      yel_hw_r    <= 8'd0;
      yel_cr_r    <= 8'd0;
      allred_r    <= 8'd0;
      flash_cnt_r <= 16'd0;
      fault_r     <= 1'b0;
      code_r      <= 3'd0;
      flash_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_ARM, ST_RUN: begin
          prev_hw_r <= bus.highway;
          prev_cr_r <= bus.cross_road;
          yel_hw_r  <= run_next(bus.highway == YEL, state_r == ST_ARM, yel_hw_r);
          yel_cr_r  <= run_next(bus.cross_road == YEL, state_r == ST_ARM, yel_cr_r);
          allred_r  <= run_next(both_red_s, state_r == ST_ARM, allred_r);
          if (viol_s != C_NONE) begin
            state_r     <= ST_FAULT;
            fault_r     <= 1'b1;
            code_r      <= viol_s;
            flash_r     <= 1'b1;
            flash_cnt_r <= 16'd0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FAULT: begin
          if (ack_ok_s) begin
            state_r     <= ST_ARM;
            fault_r     <= 1'b0;
            code_r      <= 3'd0;
            flash_r     <= 1'b0;
            flash_cnt_r <= 16'd0;
          end else if (flash_cnt_r == FLASH_TC) begin
            flash_r     <= ~flash_r;
            flash_cnt_r <= 16'd0;
          end else begin
            flash_cnt_r <= flash_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r     <= ST_ARM;
          fault_r     <= 1'b0;
          code_r      <= 3'd0;
          flash_r     <= 1'b0;
          flash_cnt_r <= 16'd0;
        end
      endcase
    end
  end

  assign bus.fault      = fault_r;
  assign bus.fault_code = code_r;
  assign bus.flash      = flash_r;
endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Independent safety monitor on the receiving end of the traffic light controller's lamp-drive outputs. Every clock it samples the highway and cross-road light codes, checks them against the intersection's safety rules (no conflicting non-red aspects, legal aspect sequence, minimum yellow, minimum all-red clearance), and latches the first violation. On a fault it drives a flash output for the lamp drivers and reports a fault code until the fault is acknowledged under safe conditions or the block is reset.

## Interface
- MIN_YELLOW, 3: minimum consecutive yellow samples before yellow→red (1..255).
- MIN_ALLRED, 2: minimum consecutive both-red samples before either road goes red→green (1..255).
- FLASH_DIV, 8: cycles per flash half-period (1..65535).
- clk  input  1  system clock, all logic on posedge.
- clear  input  1  asynchronous, active-high reset.
- highway  input  2  highway light code: red=2'b00, yellow=2'b01, green=2'b10, 2'b11 invalid.
- cross_road  input  2  cross-road light code, same encoding.
- fault_ack  input  1  request to clear a latched fault; level, sampled on posedge.
- fault  output  1  latched fault indication.
- fault_code  output  3  first violation seen; 0 when no fault.
- flash  output  1  flash drive, toggles while fault=1, 0 otherwise.

## Operation
- All outputs registered. Reset values: fault=0, fault_code=0, flash=0; internal: armed=0, prev codes=red/red, yel_cnt (per road)=0, allred_cnt=0, flash_cnt=0.
- armed=0 (first sample after reset or after a successful ack): load prev codes and counters from the current sample; only codes 1 and 2 checked; armed←1.
- Checks each armed sample, fault_code values:
  - 1 INVALID: either input = 2'b11.
  - 2 CONFLICT: both inputs non-red.
  - 3 BAD_SEQ: per road, prev→cur in {G→R, Y→G, R→Y}. Legal: G→G, G→Y, Y→Y, Y→R, R→R, R→G.
  - 4 SHORT_YELLOW: per road, Y→R with that road's yel_cnt < MIN_YELLOW.
  - 5 SHORT_CLEAR: a road R→G, prev sample both red, allred_cnt < MIN_ALLRED.
- Multiple violations in one sample: lowest code wins.
- Counters: yel_cnt←1 on a road's first yellow sample, +1 per further yellow sample, saturates at 255, ←0 on non-yellow. allred_cnt same rule for samples with both red. Counter values used in checks are values before the current sample's update.
- While fault=1: checks and counters frozen; fault_code held; further violations ignored.
- fault_ack while fault=1: accepted only if current sample is red/red; then fault←0, fault_code←0, flash←0, flash_cnt←0, armed←0. Otherwise ignored (fault stays). fault_ack while fault=0 has no effect.
- Flash: on fault assertion flash←1, flash_cnt←0; flash_cnt counts 0..FLASH_DIV-1, at terminal count flash toggles and flash_cnt←0. Period 2×FLASH_DIV cycles.
- clear asserted at any time (including mid-flash, mid-yellow) forces all reset values immediately, independent of clk.

## Timing
- Violation present in sample taken at posedge N → fault=1, fault_code valid, flash=1 after posedge N (zero added latency beyond the register).
- Accepted ack at posedge N → fault=0 after N; sample at N+1 is the re-arm sample; checks resume at N+2.
- Flash: first toggle to 0 after FLASH_DIV edges following assertion edge, then every FLASH_DIV edges.
- clear deassertion: first sample at the first posedge with clear=0 is the arm sample.

## Test plan
- Legal cycle: hw G×10, hw Y×3, R/R×2, cr G×5, cr Y×3, R/R×2, hw G → fault stays 0, fault_code=0, flash=0 throughout.
- Conflict: armed, hw=G, cr=Y at edge N → fault=1, fault_code=2 after N; flash=1 for 8 cycles, 0 for 8 (FLASH_DIV=8).
- Short yellow: hw Y×2 then R → fault_code=4; repeat with Y×3 then R → no fault.
- Priority/sequence: cr=2'b11 and hw G→R in same sample → fault_code=1; separately hw G→R alone → 3; R/R×1 then cr R→G → 5.
- Ack: fault latched, fault_ack with hw=G → ignored; fault_ack with R/R → fault=0 next edge; immediate hw R→Y on re-arm sample → no fault; same transition one sample later → fault_code=3.
- Reset mid-fault: assert clear between edges during flash → fault, fault_code, flash drop to 0 without a clock edge; after release, first sample hw=G cr=R (any prev) → no fault.
